// File: rtl/io_bank.sv
// rtl/io_bank.sv - serially configured I/O bank with shadow/active config and per-channel datapath
module io_bank #(
    parameter int CH = 4,
    parameter int W  = 8
) (
    input  logic            clb_clk,
    input  logic            rst_n,
    input  logic            prog_in,
    input  logic            prog_en,
    output logic            prog_out,
    output logic            cfg_valid,
    output logic            cfg_err,
    input  logic [CH*W-1:0] pad_in,
    output logic [CH*W-1:0] pad_out,
    output logic [CH-1:0]   pad_oe,
    input  logic [CH*W-1:0] core_out,
    output logic [CH*W-1:0] core_in
);

    localparam int CFG_LEN = 4 * CH;
    localparam int CNT_W   = $clog2(CFG_LEN + 2);

    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(CFG_LEN);
    localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(CFG_LEN + 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SHIFT  = 2'd1,
        ST_COMMIT = 2'd2
    } state_t;

    state_t               state_q;
    logic [CFG_LEN-1:0]   shadow_q;
    logic [CFG_LEN-1:0]   shadow_d;
    logic [CFG_LEN-1:0]   active_q;
    logic [CNT_W-1:0]     count_q;
    logic [CNT_W-1:0]     count_d;
    logic                 cfg_valid_q;
    logic                 cfg_err_q;

    // Next shadow value is always the one-bit shift; the FSM decides when to take it.
    assign shadow_d = {shadow_q[CFG_LEN-2:0], prog_in};

    // Saturating bit count so an overlong load can never wrap back onto CFG_LEN.
    always_comb begin
        count_d = count_q;
        if (count_q != CNT_SAT) begin
            count_d = count_q + CNT_ONE;
        end
    end

    // Configuration FSM: shifts the chain, counts bits and commits shadow into active.
    always_ff @(posedge clb_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            shadow_q    <= '0;
            active_q    <= '0;
            count_q     <= '0;
            cfg_valid_q <= 1'b0;
            cfg_err_q   <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (prog_en) begin
                        state_q  <= ST_SHIFT;
                        shadow_q <= shadow_d;
                        count_q  <= CNT_ONE;
                    end
                end
                ST_SHIFT: begin
                    if (prog_en) begin
                        shadow_q <= shadow_d;
                        count_q  <= count_d;
                    end else begin
                        // Commit happens on the edge that leaves SHIFT; only an exact-length load is accepted.
                        state_q <= ST_COMMIT;
                        if (count_q == CNT_FULL) begin
                            active_q    <= shadow_q;
                            cfg_valid_q <= 1'b1;
                            cfg_err_q   <= 1'b0;
                        end else begin
                            cfg_err_q   <= 1'b1;
                        end
                    end
                end
                ST_COMMIT: begin
                    if (prog_en) begin
                        state_q  <= ST_SHIFT;
                        shadow_q <= shadow_d;
                        count_q  <= CNT_ONE;
                    end else begin
                        state_q  <= ST_IDLE;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign prog_out  = shadow_q[CFG_LEN-1];
    assign cfg_valid = cfg_valid_q;
    assign cfg_err   = cfg_err_q;

    // Per-channel datapath, driven only by the active configuration.
    for (genvar i = 0; i < CH; i++) begin : g_ch
        logic [1:0]   mode;
        logic         reg_en;
        logic         inv;
        logic [W-1:0] src;
        logic [W-1:0] xf;
        logic [W-1:0] f;
        logic [W-1:0] pipe_q;

        assign mode   = active_q[4*i+3 -: 2];
        assign reg_en = active_q[4*i+1];
        assign inv    = active_q[4*i];

        // Input mode samples the pad; every other mode uses the core so loopback and output share one path.
        assign src = (mode == 2'b01) ? pad_in[i*W +: W] : core_out[i*W +: W];
        assign xf  = inv ? ~src : src;
        assign f   = reg_en ? pipe_q : xf;

        // Pipeline flop loads every edge so a later switch to registered mode sees fresh data.
        always_ff @(posedge clb_clk or negedge rst_n) begin
            if (!rst_n) begin
                pipe_q <= '0;
            end else begin
                pipe_q <= xf;
            end
        end

        assign core_in[i*W +: W] = (mode == 2'b01 || mode == 2'b11) ? f : '0;
        assign pad_out[i*W +: W] = (mode == 2'b10) ? f : '0;
        assign pad_oe[i]         = (mode == 2'b10);
    end

endmodule
